// File: rtl/sram_1rw1r_bypass_pkg.sv
// Shared constants and helpers for the 1RW+1R scratchpad memory wrapper.
package sram_pkg;

  localparam int SRAM_WRITE_FIRST = 0;
  localparam int SRAM_READ_FIRST  = 1;

  // Widest word the merge helper handles; callers cast in and out of this width.
  localparam int SRAM_MAX_WIDTH = 1024;
  localparam int SRAM_IDX_W     = $clog2(SRAM_MAX_WIDTH);

  typedef logic [SRAM_MAX_WIDTH-1:0] sram_word_t;

  function automatic int sram_num_be(input int data_width, input int byte_width);
    return data_width / byte_width;
  endfunction

  // Byte-masked merge: lane i of the result comes from new_word iff be[i].
  function automatic sram_word_t merge(input sram_word_t old_word,
                                       input sram_word_t new_word,
                                       input sram_word_t be,
                                       input int         byte_width);
    sram_word_t res;
    for (int i = 0; i < SRAM_MAX_WIDTH; i++) begin
      res[SRAM_IDX_W'(i)] = be[SRAM_IDX_W'(i / byte_width)] ? new_word[SRAM_IDX_W'(i)]
                                                             : old_word[SRAM_IDX_W'(i)];
    end
    return res;
  endfunction

endpackage

// File: rtl/sram_1rw1r_bypass_if.sv
// Request/response bundle for the 1RW port A and read-only port B.
interface sram_1rw1r_bypass_if
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_BE     = sram_num_be(DATA_WIDTH, 8)
);
  logic                  a_req_i;
  logic                  a_we_i;
  logic [NUM_BE-1:0]     a_be_i;
  logic [ADDR_WIDTH-1:0] a_addr_i;
  logic [DATA_WIDTH-1:0] a_wdata_i;
  logic                  a_rvalid_o;
  logic [DATA_WIDTH-1:0] a_rdata_o;
  logic                  b_req_i;
  logic [ADDR_WIDTH-1:0] b_addr_i;
  logic                  b_rvalid_o;
  logic [DATA_WIDTH-1:0] b_rdata_o;
  logic                  collision_o;

  modport slave (
    input  a_req_i, a_we_i, a_be_i, a_addr_i, a_wdata_i, b_req_i, b_addr_i,
    output a_rvalid_o, a_rdata_o, b_rvalid_o, b_rdata_o, collision_o
  );

  modport master (
    output a_req_i, a_we_i, a_be_i, a_addr_i, a_wdata_i, b_req_i, b_addr_i,
    input  a_rvalid_o, a_rdata_o, b_rvalid_o, b_rdata_o, collision_o
  );
endinterface

// File: rtl/sram_1rw1r_bypass_array.sv
// Raw storage: byte-masked synchronous write on A, synchronous reads on A and B.
// Reads return the word as it was before a same-edge write (read-first).
module sram_array
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int BYTE_WIDTH = 8,
  parameter int NUM_BE     = 4
) (
  input  logic                  clk_i,
  input  logic                  a_we_i,
  input  logic                  a_re_i,
  input  logic [NUM_BE-1:0]     a_be_i,
  input  logic [ADDR_WIDTH-1:0] a_addr_i,
  input  logic [DATA_WIDTH-1:0] a_wdata_i,
  output logic [DATA_WIDTH-1:0] a_rdata_o,
  input  logic                  b_re_i,
  input  logic [ADDR_WIDTH-1:0] b_addr_i,
  output logic [DATA_WIDTH-1:0] b_rdata_o
);
  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] a_rdata_q;
  logic [DATA_WIDTH-1:0] b_rdata_q;

  // Storage update and read registers; contents stay undefined until written.
  // NOTE: memories get no reset -- a reset would turn the macro into a flop array
  // with a huge reset fan-out; the wrapper's valid tracking masks stale data.
  always_ff @(posedge clk_i) begin
    if (a_we_i) begin
      mem_q[a_addr_i] <= DATA_WIDTH'(merge(sram_word_t'(mem_q[a_addr_i]),
                                           sram_word_t'(a_wdata_i),
                                           sram_word_t'(a_be_i), BYTE_WIDTH));
    end
    if (a_re_i) a_rdata_q <= mem_q[a_addr_i];
    if (b_re_i) b_rdata_q <= mem_q[b_addr_i];
  end

  assign a_rdata_o = a_rdata_q;
  assign b_rdata_o = b_rdata_q;
endmodule

// File: rtl/sram_1rw1r_bypass.sv
// 1RW+1R memory wrapper: request pipeline, valid tracking, collision detection,
// write-first bypass for port B and optional second output register stage.
module sram_1rw1r_bypass
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int BYTE_WIDTH     = 8,
  parameter int READ_LATENCY   = 1,
  parameter int COLLISION_MODE = SRAM_WRITE_FIRST
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  sram_1rw1r_bypass_if.slave   bus
);
  localparam int NUM_BE = sram_num_be(DATA_WIDTH, BYTE_WIDTH);

  if ((DATA_WIDTH % BYTE_WIDTH) != 0 || (READ_LATENCY != 1 && READ_LATENCY != 2) ||
      (COLLISION_MODE != SRAM_WRITE_FIRST && COLLISION_MODE != SRAM_READ_FIRST)) begin : g_bad_params
    $error("sram_1rw1r_bypass: illegal DATA_WIDTH/BYTE_WIDTH, READ_LATENCY or COLLISION_MODE");
  end

  logic                  a_wr_acc, a_rd_acc, b_rd_acc, col_acc;
  logic [DATA_WIDTH-1:0] arr_a_rdata, arr_b_rdata, b_fwd_data;
  logic                  a_vld1_q, b_vld1_q, col1_q;

  assign a_wr_acc = bus.a_req_i & bus.a_we_i;
  assign a_rd_acc = bus.a_req_i & ~bus.a_we_i;
  assign b_rd_acc = bus.b_req_i;
  assign col_acc  = a_wr_acc & b_rd_acc & (bus.a_addr_i == bus.b_addr_i);

  sram_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .BYTE_WIDTH (BYTE_WIDTH),
    .NUM_BE     (NUM_BE)
  ) u_array (
    .clk_i     (clk_i),
    .a_we_i    (a_wr_acc),
    .a_re_i    (a_rd_acc),
    .a_be_i    (bus.a_be_i),
    .a_addr_i  (bus.a_addr_i),
    .a_wdata_i (bus.a_wdata_i),
    .a_rdata_o (arr_a_rdata),
    .b_re_i    (b_rd_acc),
    .b_addr_i  (bus.b_addr_i),
    .b_rdata_o (arr_b_rdata)
  );

  // Stage 1: track which ports have read data arriving from the array.
  // NOTE: sequential state uses <= so every register samples pre-edge values;
  // blocking = here would make later registers see this edge's updates.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_vld1_q <= 1'b0;
      b_vld1_q <= 1'b0;
      col1_q   <= 1'b0;
    end else begin
      a_vld1_q <= a_rd_acc;
      b_vld1_q <= b_rd_acc;
      col1_q   <= col_acc;
    end
  end

  if (COLLISION_MODE == SRAM_WRITE_FIRST) begin : g_write_first
    logic [NUM_BE-1:0]     col_be_q;
    logic [DATA_WIDTH-1:0] col_wdata_q;

    // Capture the colliding write so it can be folded into port B's old word.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        col_be_q    <= '0;
        col_wdata_q <= '0;
      end else if (col_acc) begin
        col_be_q    <= bus.a_be_i;
        col_wdata_q <= bus.a_wdata_i;
      end
    end

    // Bypass mux: on a collision port B sees the freshly written lanes.
    // NOTE: the default assignment first keeps this always_comb free of latches.
    always_comb begin
      b_fwd_data = arr_b_rdata;
      if (col1_q) begin
        b_fwd_data = DATA_WIDTH'(merge(sram_word_t'(arr_b_rdata), sram_word_t'(col_wdata_q),
                                       sram_word_t'(col_be_q), BYTE_WIDTH));
      end
    end
  end else begin : g_read_first
    assign b_fwd_data = arr_b_rdata;
  end

  if (READ_LATENCY == 1) begin : g_lat1
    logic [DATA_WIDTH-1:0] a_hold_q, b_hold_q, a_rdata_d, b_rdata_d;

    assign a_rdata_d = a_vld1_q ? arr_a_rdata : a_hold_q;
    assign b_rdata_d = b_vld1_q ? b_fwd_data  : b_hold_q;

    // Hold registers keep the last returned word while rvalid is low.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        a_hold_q <= '0;
        b_hold_q <= '0;
      end else begin
        a_hold_q <= a_rdata_d;
        b_hold_q <= b_rdata_d;
      end
    end

    assign bus.a_rvalid_o  = a_vld1_q;
    assign bus.a_rdata_o   = a_rdata_d;
    assign bus.b_rvalid_o  = b_vld1_q;
    assign bus.b_rdata_o   = b_rdata_d;
    assign bus.collision_o = col1_q;
  end else begin : g_lat2
    logic                  a_vld2_q, b_vld2_q, col2_q;
    logic [DATA_WIDTH-1:0] a_data2_q, b_data2_q;

    // Output register stage; data only loads on a valid beat so it holds otherwise.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        a_vld2_q  <= 1'b0;
        b_vld2_q  <= 1'b0;
        col2_q    <= 1'b0;
        a_data2_q <= '0;
        b_data2_q <= '0;
      end else begin
        a_vld2_q <= a_vld1_q;
        b_vld2_q <= b_vld1_q;
        col2_q   <= col1_q;
        if (a_vld1_q) a_data2_q <= arr_a_rdata;
        if (b_vld1_q) b_data2_q <= b_fwd_data;
      end
    end

    assign bus.a_rvalid_o  = a_vld2_q;
    assign bus.a_rdata_o   = a_data2_q;
    assign bus.b_rvalid_o  = b_vld2_q;
    assign bus.b_rdata_o   = b_data2_q;
    assign bus.collision_o = col2_q;
  end
endmodule
